posit_decode_pipe: RTL and testbench
====================================

Name: posit_decode_pipe

Overview:
- Streaming, pipelined posit field decoder for the posit multiplier datapath.
- Each beat carries LANES independent N-bit posits. For each posit it produces sign, regime value k, exponent, hidden-bit mantissa and NaR/zero flags.
- Sits between the operand input buffer and the multiplier core. Uses a valid/ready handshake with full backpressure, so the core can stall without losing operands.

Parameters:
- N, 16, posit word width (>=4)
- ES, 1, exponent field width (0..N-3)
- LANES, 1, posits decoded per beat
- RS, $clog2(N), regime-count width base; k is RS+2 bits signed

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*N  posits; lane i at [i*N +: N]
- out_valid  out  1  decoded beat valid
- out_ready  in  1  consumer accepts the beat
- out_sign  out  LANES  sign bit per lane
- out_k  out  LANES*(RS+2)  signed regime value per lane
- out_exp  out  LANES*ES  exponent per lane (absent when ES=0)
- out_mant  out  LANES*N  mantissa per lane; MSB is the hidden 1
- out_inf  out  LANES  lane is NaR (1 followed by all 0)
- out_zero  out  LANES  lane is all 0

Behaviour:
- Two register stages, S1 and S2. Each stage has a valid flag.
- Per-lane decode:
  - sign = bit N-1.
  - mag[N-2:0] = the low N-1 bits of the 2's complement of the word if sign=1, else the word's low N-1 bits.
  - Regime run: m identical bits starting at mag[N-2], 1<=m<=N-1.
  - k = m-1 if the run bit is 1; k = -m if it is 0.
  - Terminator bit follows the run (absent when m=N-1).
  - Next ES bits form the exponent. Bits past the word end read as 0.
  - Remaining bits form the fraction, left-aligned.
  - mant = {1'b1, fraction, zero pad} to N bits.
- S1 registers: sign, mag, inf, zero.
- S2 registers: regime detect, shift, and field extraction outputs.
- Latency: exactly 2 cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - S2 loads when out_ready || !S2.valid.
  - S1 loads when S2 can load || !S1.valid.
  - in_ready = S1 load enable. This is combinational from out_ready and the stage valids; there is no skid buffer.
  - While out_valid=1 && out_ready=0, all out_* hold stable.
  - A stage whose upstream is invalid and which loads becomes invalid.
- Specials:
  - inf=1 or zero=1 forces k=0, exp=0, mant=0 for that lane.
  - sign passes through unchanged (1 for NaR).
- Simultaneous events:
  - Input accept and output drain in the same cycle: both occur, and occupancy is unchanged.
  - Full pipe (2 beats) with out_ready=0 gives in_ready=0.
- Reset (asynchronous, any time, including mid-stream):
  - S1/S2 valid = 0, so out_valid = 0 and in_ready = 1 after reset release.
  - All data registers and out_* = 0.
  - In-flight beats are dropped.
- in_data is sampled only on an accepted transfer. It is ignored while in_valid=0.
- Lanes are fully independent. There is no cross-lane arithmetic.

Decomposition:
- Package posit_pkg holds:
  - function regime_width(N) returning $clog2(N)+2;
  - NaR/zero pattern constants;
  - typedef posit_fields_t (sign, k, exp, mant, inf, zero), parameterised via localparams at the default N/ES.
- Sub-module posit_regime_detect (combinational), instantiated LANES times in S2:
  - input: mag;
  - outputs: run length m and run polarity.
- All registers and the handshake logic stay in posit_decode_pipe.

Test Plan:
- Reset then single beat 0x4000, out_ready=1 -> out_valid 2 cycles later; sign=0, k=0, exp=0, mant=0x8000.
- Beats 0x5A00, 0xC000, 0x7FFF, 0x0001 back-to-back ->
  - 0x5A00: k=0, exp=1, mant=0xD000;
  - 0xC000: sign=1, k=0, exp=0, mant=0x8000;
  - 0x7FFF: k=14, exp=0, mant=0x8000;
  - 0x0001: k=-14, exp=0, mant=0x8000.
  - One output per cycle, in order.
- Specials: 0x8000 -> inf=1, sign=1, k=0, mant=0; 0x0000 -> zero=1, all fields 0.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; out_* stable; all 4 beats emerge in order once out_ready=1.
- Mid-stream reset: assert rst_n=0 with 2 beats in flight -> out_valid=0 and out_* = 0 immediately; in_ready=1 after release; no stale beat appears.
- LANES=2, in_data={0x0001,0x5A00} -> lane0 k=0, exp=1, mant=0xD000; lane1 k=-14, mant=0x8000.

Source files
------------

// File: rtl/posit_pkg.sv
// Shared posit constants, field record and width helpers for the multiplier datapath.
package posit_pkg;

    function automatic int regime_width(input int n);
        return $clog2(n) + 2;
    endfunction

    localparam int P_N  = 16;
    localparam int P_ES = 1;
    localparam int P_KW = regime_width(P_N);

    localparam logic [P_N-1:0] NAR_PAT  = {1'b1, {(P_N-1){1'b0}}};
    localparam logic [P_N-1:0] ZERO_PAT = '0;

    typedef struct packed {
        logic                   sign;
        logic signed [P_KW-1:0] k;
        logic [P_ES-1:0]        exp;
        logic [P_N-1:0]         mant;
        logic                   inf;
        logic                   zero;
    } posit_fields_t;

endpackage

// File: rtl/posit_regime_detect.sv
// Regime run detector: length and polarity of the leading run of identical bits in mag.
// Purely combinational; a run spanning the whole field reports N-1.
module posit_regime_detect #(
    parameter int N  = 16,
    parameter int RS = $clog2(N)
) (
    input  logic [N-2:0]  mag,
    output logic [RS-1:0] run_len,
    output logic          run_bit
);

    // Highest bit differing from the run bit marks the terminator; later iterations win.
    always_comb begin
        run_bit = mag[N-2];
        run_len = RS'(N - 1);
        for (int i = 0; i < N - 2; i++) begin
            if (mag[i] != run_bit) run_len = RS'(N - 2 - i);
        end
    end

endmodule

// File: rtl/posit_decode_pipe.sv
// Posit field decoder: per lane sign, regime k, exponent, hidden-bit mantissa, NaR/zero flags.
// Latency 2 cycles (S1 magnitude, S2 regime/extract), 1 beat/cycle throughput.
// Full backpressure: in_ready is combinational from out_ready and stage valids, no skid buffer.
module posit_decode_pipe
    import posit_pkg::*;
#(
    parameter int N     = 16,
    parameter int ES    = 1,
    parameter int LANES = 1,
    parameter int RS    = $clog2(N)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*N-1:0]                   in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES-1:0]                     out_sign,
    output logic [LANES*(RS+2)-1:0]              out_k,
    output logic [LANES*((ES > 0) ? ES : 1)-1:0] out_exp,
    output logic [LANES*N-1:0]                   out_mant,
    output logic [LANES-1:0]                     out_inf,
    output logic [LANES-1:0]                     out_zero
);

    localparam int KW = RS + 2;
    localparam int EW = (ES > 0) ? ES : 1;

    logic s1_vld, s2_vld, s1_ld, s2_ld;

    logic         s1_sign [LANES];
    logic [N-2:0] s1_mag  [LANES];
    logic         s1_inf  [LANES];
    logic         s1_zero [LANES];

    logic         sign_c  [LANES];
    logic [N-2:0] mag_c   [LANES];
    logic         inf_c   [LANES];
    logic         zero_c  [LANES];
    logic [KW-1:0] k_c    [LANES];
    logic [EW-1:0] exp_c  [LANES];
    logic [N-1:0]  mant_c [LANES];

    logic          q_sign [LANES];
    logic [KW-1:0] q_k    [LANES];
    logic [EW-1:0] q_exp  [LANES];
    logic [N-1:0]  q_mant [LANES];
    logic          q_inf  [LANES];
    logic          q_zero [LANES];

    assign s2_ld     = out_ready || !s2_vld;
    assign s1_ld     = s2_ld || !s1_vld;
    assign in_ready  = s1_ld;
    assign out_valid = s2_vld;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [N-1:0]  word;
        logic [RS-1:0] run_len;
        logic          run_bit;
        logic [N-2:0]  rest;
        logic          special;

        assign word      = in_data[g*N +: N];
        assign sign_c[g] = word[N-1];
        assign mag_c[g]  = word[N-1] ? (~word[N-2:0] + 1'b1) : word[N-2:0];
        assign inf_c[g]  = (word == {1'b1, {(N-1){1'b0}}});
        assign zero_c[g] = (word == '0);

        posit_regime_detect #(.N(N), .RS(RS)) u_regime (
            .mag     (s1_mag[g]),
            .run_len (run_len),
            .run_bit (run_bit)
        );

        // Drop the run and its terminator; bits shifted in past the word end are 0.
        assign rest      = s1_mag[g] << (32'(run_len) + 32'd1);
        assign special   = s1_inf[g] || s1_zero[g];
        assign k_c[g]    = special ? '0 :
                           run_bit ? (KW'(run_len) - KW'(1)) : (KW'(0) - KW'(run_len));
        assign mant_c[g] = special ? '0 : {1'b1, rest << ES};
        if (ES > 0) begin : g_exp
            assign exp_c[g] = special ? '0 : rest[N-2 -: EW];
        end else begin : g_noexp
            assign exp_c[g] = '0;
        end

        assign out_sign[g]          = q_sign[g];
        assign out_k[g*KW +: KW]    = q_k[g];
        assign out_exp[g*EW +: EW]  = q_exp[g];
        assign out_mant[g*N +: N]   = q_mant[g];
        assign out_inf[g]           = q_inf[g];
        assign out_zero[g]          = q_zero[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_sign[i] <= 1'b0;
                s1_mag[i]  <= '0;
                s1_inf[i]  <= 1'b0;
                s1_zero[i] <= 1'b0;
                q_sign[i]  <= 1'b0;
                q_k[i]     <= '0;
                q_exp[i]   <= '0;
                q_mant[i]  <= '0;
                q_inf[i]   <= 1'b0;
                q_zero[i]  <= 1'b0;
            end
        end else begin
            if (s1_ld) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        s1_sign[i] <= sign_c[i];
                        s1_mag[i]  <= mag_c[i];
                        s1_inf[i]  <= inf_c[i];
                        s1_zero[i] <= zero_c[i];
                    end
                end
            end
            if (s2_ld) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    for (int i = 0; i < LANES; i++) begin
                        q_sign[i] <= s1_sign[i];
                        q_k[i]    <= k_c[i];
                        q_exp[i]  <= exp_c[i];
                        q_mant[i] <= mant_c[i];
                        q_inf[i]  <= s1_inf[i];
                        q_zero[i] <= s1_zero[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Scoreboard bench for posit_decode_pipe: single-lane instance plus a two-lane instance.
module tb_posit_decode_pipe;
    import posit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data;
    logic [0:0]  out_sign, out_inf, out_zero, out_exp;
    logic [5:0]  out_k;
    logic [15:0] out_mant;

    logic        in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] in_data2;
    logic [1:0]  out_sign2, out_inf2, out_zero2, out_exp2;
    logic [11:0] out_k2;
    logic [31:0] out_mant2;

    int tests = 0;
    int fails = 0;
    int accepts = 0;
    int beat_no = 0;

    posit_fields_t exp_q[$];
    logic [49:0]   exp_q2[$];

    always #5 clk = ~clk;

    posit_decode_pipe #(.N(16), .ES(1), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_k(out_k),
        .out_exp(out_exp), .out_mant(out_mant), .out_inf(out_inf), .out_zero(out_zero)
    );

    posit_decode_pipe #(.N(16), .ES(1), .LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_sign(out_sign2), .out_k(out_k2),
        .out_exp(out_exp2), .out_mant(out_mant2), .out_inf(out_inf2), .out_zero(out_zero2)
    );

    function automatic posit_fields_t mk(input logic s, input int k, input logic e,
                                         input logic [15:0] m, input logic inf, input logic z);
        posit_fields_t f;
        f.sign = s; f.k = 6'(k); f.exp = e; f.mant = m; f.inf = inf; f.zero = z;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Present a beat and hold it until accepted; expectation is queued before the accept edge.
    task automatic send(input logic [15:0] d, input posit_fields_t e);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepts++;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL send_timeout: data %h never accepted", d);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 50 && (exp_q.size() != 0 || exp_q2.size() != 0); c++) @(posedge clk);
        #1;
    endtask

    posit_fields_t act, held_val;
    bit            held = 0;

    always @(negedge clk) begin
        act = {out_sign, out_k, out_exp, out_mant, out_inf, out_zero};
        if (!rst_n) begin
            held = 0;
        end else begin
            if (held) begin
                tests++;
                if (!out_valid || act !== held_val) begin
                    fails++;
                    $display("FAIL stall_hold: got vld=%b %h expected vld=1 %h", out_valid, act, held_val);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h expected no output", act);
                end else begin
                    posit_fields_t e;
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL beat%0d: got %h expected %h", beat_no, act, e);
                    end
                end
                beat_no++;
            end
            held     = out_valid && !out_ready;
            held_val = act;
            if (out_valid2 && out_ready2) begin
                logic [49:0] a2;
                a2 = {out_sign2, out_k2, out_exp2, out_mant2, out_inf2, out_zero2};
                tests++;
                if (exp_q2.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat_lanes2: got %h expected no output", a2);
                end else begin
                    logic [49:0] e2;
                    e2 = exp_q2.pop_front();
                    if (a2 !== e2) begin
                        fails++;
                        $display("FAIL lanes2_beat: got %h expected %h", a2, e2);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_mant", 32'(out_mant), 32'd0);

        // Latency: accepted at edge E, visible after E+1.
        @(posedge clk); #1;
        send(16'h4000, mk(0, 0, 0, 16'h8000, 0, 0));
        check("latency_cycle1_vld", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_cycle2_vld", 32'(out_valid), 32'd1);
        wait_drain();

        send(16'h5A00, mk(0, 0, 1, 16'hD000, 0, 0));
        send(16'hC000, mk(1, 0, 0, 16'h8000, 0, 0));
        send(16'h7FFF, mk(0, 14, 0, 16'h8000, 0, 0));
        send(16'h0001, mk(0, -14, 0, 16'h8000, 0, 0));
        send(16'h8000, mk(1, 0, 0, 16'h0000, 1, 0));
        send(16'h0000, mk(0, 0, 0, 16'h0000, 0, 1));
        wait_drain();

        // Backpressure: only two beats fit while the consumer stalls.
        accepts = 0;
        fork
            begin
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_accepts", 32'(accepts), 32'd2);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                out_ready = 1'b1;
            end
            begin
                send(16'h5A00, mk(0, 0, 1, 16'hD000, 0, 0));
                send(16'h7FFF, mk(0, 14, 0, 16'h8000, 0, 0));
                send(16'h0001, mk(0, -14, 0, 16'h8000, 0, 0));
                send(16'hC000, mk(1, 0, 0, 16'h8000, 0, 0));
            end
        join
        wait_drain();

        // Mid-stream reset with two beats in flight; they must vanish.
        in_valid = 1'b1; in_data = 16'h7FFF;
        @(posedge clk); #1;
        in_data = 16'h5A00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_k", 32'(out_k), 32'd0);
        check("rst_out_mant", 32'(out_mant), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("rst_no_stale", 32'(out_valid), 32'd0);
        send(16'h4000, mk(0, 0, 0, 16'h8000, 0, 0));
        wait_drain();

        // Two lanes: lane0 0x5A00, lane1 0x0001 (k=-14 -> 6'h32).
        in_valid2 = 1'b1; in_data2 = {16'h0001, 16'h5A00};
        exp_q2.push_back({2'b00, 6'h32, 6'h00, 2'b01, 16'h8000, 16'hD000, 2'b00, 2'b00});
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        wait_drain();

        if (exp_q.size() != 0 || exp_q2.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d/%0d beats pending expected 0", exp_q.size(), exp_q2.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
